serial_adder: RTL and testbench



---
 rtl/serial_adder_if.sv | 26 ++
 rtl/serial_adder.sv | 92 +++++++++
 tb/tb_serial_adder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Start/busy/done handshake and operand/result bundle for the bit-serial adder.
// master drives the request side, slave is the adder itself.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder/subtractor: one full-adder slice reused over
// WIDTH cycles, LSB first, with a registered carry and a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  logic             carry;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic [1:0]       fa;
  logic             accept;
  logic             last;

  // Returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    full_add = {(x & y) | (x & c) | (y & c), x ^ y ^ c};
  endfunction

  assign accept = (state == S_IDLE) && bus.start;
  assign last   = (bit_cnt == LAST_BIT);
  assign fa     = full_add(opa[0], opb[0], carry);

  // Control: FSM, bit counter, carry and the architectural result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      carry   <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state   <= S_RUN;
            bit_cnt <= '0;
            carry   <= bus.sub | bus.cin;
          end
        end
        S_RUN: begin
          carry   <= fa[1];
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (last) begin
            state  <= S_DONE;
            sum_r  <= {fa[0], res_sh[WIDTH-1:1]};
            cout_r <= fa[1];
            // On the last bit the carry register still holds the carry into the MSB.
            ovf_r  <= carry ^ fa[1];
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath: operand shift registers and result shift register, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      opa <= bus.a;
      opb <= bus.sub ? ~bus.b : bus.b;
    end else if (state == S_RUN) begin
      opa    <= opa >> 1;
      opb    <= opb >> 1;
      res_sh <= {fa[0], res_sh[WIDTH-1:1]};
    end
  end

  assign bus.busy = (state == S_RUN);
  assign bus.done = (state == S_DONE);
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed literal checks on an 8-bit instance, then a
// randomized sweep of WIDTH 2/8/32 instances compared every cycle to an arithmetic model.
module tb_serial_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int  npass = 0;
  int  ntotal = 0;
  logic sweep_go = 1'b0;

  // Directed 8-bit instance
  logic rst_n;
  serial_adder_if #(.WIDTH(8)) dbus ();
  serial_adder #(.WIDTH(8)) dut_d (.clk(clk), .rst_n(rst_n), .bus(dbus));

  // Randomized sweep instances, each with its own behavioural model
  for (genvar gi = 0; gi < 3; gi++) begin : g_sw
    localparam int W = (gi == 0) ? 2 : (gi == 1) ? 8 : 32;
    serial_adder_if #(.WIDTH(W)) bus ();
    logic rst_n_s = 1'b0;
    serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n_s), .bus(bus));

    int         ops = 0;
    int         cnt = -1;
    logic       finished = 1'b0;
    logic       e_busy = 1'b0, e_done = 1'b0, e_cout = 1'b0, e_ovf = 1'b0;
    logic [W-1:0] e_sum = '0;
    logic [W-1:0] p_sum;
    logic       p_cout, p_ovf;

    // Model: cnt counts edges since the accepting edge; results from plain arithmetic.
    initial forever begin
      longint ua, ub, us, sa, sb, sv, smax;
      @(posedge clk);
      if (!rst_n_s) begin
        cnt = -1; e_sum = '0; e_cout = 1'b0; e_ovf = 1'b0;
      end else if (cnt < 0) begin
        if (bus.start) begin
          ua = longint'(bus.a);
          ub = longint'(bus.b);
          sa = longint'($signed(bus.a));
          sb = longint'($signed(bus.b));
          smax = (longint'(1) << (W - 1)) - 1;
          if (bus.sub) begin
            us = ua - ub;
            sv = sa - sb;
            p_cout = (ua >= ub);
          end else begin
            us = ua + ub + longint'(bus.cin);
            sv = sa + sb + longint'(bus.cin);
            p_cout = (us >= (longint'(1) << W));
          end
          p_sum = W'(us);
          p_ovf = (sv > smax) || (sv < -smax - 1);
          cnt = 0;
          ops++;
        end
      end else begin
        cnt++;
        if (cnt == W) begin
          e_sum = p_sum; e_cout = p_cout; e_ovf = p_ovf;
        end else if (cnt == W + 1) begin
          cnt = -1;
        end
      end
      e_busy = (cnt >= 0) && (cnt < W);
      e_done = (cnt == W);
    end

    // Stimulus: every input re-randomized each cycle, occasional reset pulses.
    initial begin
      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
      wait (sweep_go);
      @(posedge clk); #1;
      rst_n_s = 1'b1;
      for (int c = 0; c < 500 * (W + 2) * 2 && ops < 500; c++) begin
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'($urandom_range(0, 1));
        bus.sub   = 1'($urandom_range(0, 1));
        bus.start = ($urandom_range(0, 3) != 0);
        rst_n_s   = ($urandom_range(0, 299) != 0);
        @(posedge clk); #1;
      end
      bus.start = 1'b0;
      rst_n_s = 1'b1;
      repeat (W + 3) @(posedge clk);
      #1 finished = 1'b1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic cmp_out(input string nm,
                         input logic b, input logic d, input logic [31:0] s, input logic c, input logic o,
                         input logic eb, input logic ed, input logic [31:0] es, input logic ec, input logic eo);
    ntotal++;
    if (b === eb && d === ed && s === es && c === ec && o === eo) npass++;
    else $display("FAIL %s t=%0t: got busy=%b done=%b sum=%0h cout=%b ovf=%b, expected busy=%b done=%b sum=%0h cout=%b ovf=%b",
                  nm, $time, b, d, s, c, o, eb, ed, es, ec, eo);
  endtask

  // Called at #1 after an edge with the DUT idle; returns at #1 after the edge back to IDLE.
  task automatic run_op(input string nm, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tcin, input logic tsub,
                        input logic [7:0] esum, input logic ecout, input logic eovf);
    int lat;
    dbus.a = ta; dbus.b = tb_v; dbus.cin = tcin; dbus.sub = tsub; dbus.start = 1'b1;
    @(posedge clk); #1;
    dbus.start = 1'b0;
    dbus.a = ~ta; dbus.b = ~tb_v; dbus.sub = ~tsub; dbus.cin = ~tcin;
    lat = 0;
    while (!dbus.done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, lat, 8);
    check({nm, "_sum"}, 32'(dbus.sum), 32'(esum));
    check({nm, "_cout"}, 32'(dbus.cout), 32'(ecout));
    check({nm, "_ovf"}, 32'(dbus.ovf), 32'(eovf));
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int dones;
    rst_n = 1'b0;
    dbus.start = 1'b0; dbus.a = '0; dbus.b = '0; dbus.cin = 1'b0; dbus.sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(dbus.busy), 0);
    check("reset_done", 32'(dbus.done), 0);
    check("reset_sum",  32'(dbus.sum),  0);
    check("reset_cout", 32'(dbus.cout), 0);
    check("reset_ovf",  32'(dbus.ovf),  0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_5a_33",   8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1);
    run_op("add_ff_01",   8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_ff_00_c", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("sub_10_20",   8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
    run_op("sub_80_01",   8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Start held high, operands scrambled every cycle of the run.
    dbus.a = 8'h12; dbus.b = 8'h34; dbus.cin = 1'b0; dbus.sub = 1'b0; dbus.start = 1'b1;
    @(posedge clk); #1;
    check("hs_busy_e0", 32'(dbus.busy), 1);
    check("hs_hold_prev", 32'(dbus.sum), 32'h7F);
    for (int k = 1; k <= 8; k++) begin
      dbus.a = 8'($urandom); dbus.b = 8'($urandom); dbus.cin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    check("hs_done_e8", 32'(dbus.done), 1);
    check("hs_busy_e8", 32'(dbus.busy), 0);
    check("hs_sum", 32'(dbus.sum), 32'h46);
    dbus.a = 8'h01; dbus.b = 8'h02; dbus.cin = 1'b0;
    @(posedge clk); #1;
    check("hs_idle_e9", {30'd0, dbus.busy, dbus.done}, 0);
    @(posedge clk); #1;
    check("hs_accept_e10", 32'(dbus.busy), 1);
    dbus.start = 1'b0; dbus.a = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("hs_sum_holds", 32'(dbus.sum), 32'h46);
    lat = 3;
    while (!dbus.done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("hs2_latency", lat, 8);
    check("hs2_sum", 32'(dbus.sum), 32'h03);
    @(posedge clk); #1;

    // Reset aborts an operation at bit 3.
    dbus.a = 8'h5A; dbus.b = 8'h33; dbus.cin = 1'b0; dbus.sub = 1'b0; dbus.start = 1'b1;
    @(posedge clk); #1;
    dbus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("abort_busy", 32'(dbus.busy), 0);
    check("abort_done", 32'(dbus.done), 0);
    check("abort_sum",  32'(dbus.sum),  0);
    check("abort_cout", 32'(dbus.cout), 0);
    check("abort_ovf",  32'(dbus.ovf),  0);
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (dbus.done) dones++;
    end
    check("abort_no_done", dones, 0);
    run_op("post_abort", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1);

    // Randomized sweep, every cycle compared against the models.
    sweep_go = 1'b1;
    for (int c = 0; c < 40000; c++) begin
      @(negedge clk);
      cmp_out("sweep_w2", g_sw[0].bus.busy, g_sw[0].bus.done, 32'(g_sw[0].bus.sum), g_sw[0].bus.cout, g_sw[0].bus.ovf,
              g_sw[0].e_busy, g_sw[0].e_done, 32'(g_sw[0].e_sum), g_sw[0].e_cout, g_sw[0].e_ovf);
      cmp_out("sweep_w8", g_sw[1].bus.busy, g_sw[1].bus.done, 32'(g_sw[1].bus.sum), g_sw[1].bus.cout, g_sw[1].bus.ovf,
              g_sw[1].e_busy, g_sw[1].e_done, 32'(g_sw[1].e_sum), g_sw[1].e_cout, g_sw[1].e_ovf);
      cmp_out("sweep_w32", g_sw[2].bus.busy, g_sw[2].bus.done, 32'(g_sw[2].bus.sum), g_sw[2].bus.cout, g_sw[2].bus.ovf,
              g_sw[2].e_busy, g_sw[2].e_done, 32'(g_sw[2].e_sum), g_sw[2].e_cout, g_sw[2].e_ovf);
      if (g_sw[0].finished && g_sw[1].finished && g_sw[2].finished) break;
    end
    check("sweep_complete", {29'd0, g_sw[0].finished, g_sw[1].finished, g_sw[2].finished}, 32'h7);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
